// File: rtl/relu_arbiter.sv
// Round-robin arbiter sharing one registered ReLU stage among N_REQ valid/ready
// requesters; each result is tagged with the id of the channel that produced it.
module relu_arbiter #(
  parameter int               N_REQ     = 4,
  parameter int               BURST     = 4,
  parameter logic signed [7:0] THRESHOLD = 8'sd0,
  localparam int              IDW       = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic [IDW-1:0]     out_id,
  input  logic               out_ready,
  output logic               busy
);
  localparam int              CW       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(BURST - 1);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(N_REQ - 1);
  localparam logic [IDW:0]    N_WIDE   = (IDW+1)'(N_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q;
  logic [IDW-1:0]    g_q;
  logic [IDW-1:0]    ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic [IDW-1:0]    out_id_q;

  logic signed [7:0] data_arr [N_REQ];
  logic [2*N_REQ-1:0] valid_dbl;
  logic [N_REQ-1:0]  valid_rot;
  logic [IDW:0]      off_d;
  logic [IDW:0]      sum_d;
  logic [IDW-1:0]    pick_d;
  logic [IDW-1:0]    next_ptr_d;
  logic signed [7:0] sel_d;
  logic [7:0]        relu_d;
  logic              slot_free;
  logic              xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Rotate the request vector so bit 0 is the channel at ptr; the lowest set
  // bit then gives the round-robin winner's offset from ptr.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = valid_dbl[ptr_q +: N_REQ];

  always_comb begin
    off_d = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) off_d = (IDW+1)'(k);
    end
  end

  assign sum_d      = {1'b0, ptr_q} + off_d;
  assign pick_d     = (sum_d >= N_WIDE) ? IDW'(sum_d - N_WIDE) : IDW'(sum_d);
  assign next_ptr_d = (g_q == ID_LAST) ? '0 : g_q + 1'b1;

  assign sel_d  = data_arr[g_q];
  assign relu_d = (sel_d > THRESHOLD) ? sel_d : 8'sd0;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && slot_free && !rst) req_ready[g_q] = 1'b1;
  end

  assign xfer = req_valid[g_q] && req_ready[g_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= relu_d;
        out_id_q    <= g_q;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            g_q     <= pick_d;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (cnt_q == CNT_LAST) begin
              ptr_q   <= next_ptr_d;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (!req_valid[g_q]) begin
            ptr_q   <= next_ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q == GRANT) || out_valid_q;

endmodule
